// File: rtl/decimal_hex_display_if.sv
// ---------------------------------------------------------------------------
// decimal_hex_display_if
//   Bundles the value/display signals of decimal_hex_display.
//   value_in : unsigned value to show (driven by the master)
//   hex_out  : packed active-low segments, [6:0] = HEX0 (ones digit)
//   busy     : conversion in flight
//   done     : one-cycle pulse on the edge that commits hex_out
//   modport master : producer of value_in, consumer of the display outputs
//   modport slave  : the converter itself
// ---------------------------------------------------------------------------
interface decimal_hex_display_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIGITS     = 6
);
    logic [DATA_WIDTH-1:0] value_in;
    logic [DIGITS*7-1:0]   hex_out;
    logic                  busy;
    logic                  done;

    modport master (
        output value_in,
        input  hex_out,
        input  busy,
        input  done
    );

    modport slave (
        input  value_in,
        output hex_out,
        output busy,
        output done
    );
endinterface

// File: rtl/decimal_hex_display.sv
// ---------------------------------------------------------------------------
// decimal_hex_display
//   Sequential binary-to-decimal converter driving DIGITS active-low 7-segment
//   displays. One decimal digit is extracted per clock; the full set of
//   segments is committed to hex_out on a single edge so partially converted
//   values never reach the displays. The value shown is value_in mod 10^DIGITS.
//   Ports:
//     clk   : free-running clock, rising-edge
//     rst_n : asynchronous active-low reset (displays blank)
//     bus   : slave side of decimal_hex_display_if (value_in, hex_out, busy, done)
//   DIGITS must be at least 2.
// ---------------------------------------------------------------------------
module decimal_hex_display #(
    parameter int DATA_WIDTH = 32,
    parameter int DIGITS     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decimal_hex_display_if.slave bus
);
    localparam int CNT_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DIGITS - 1);
    localparam logic [DATA_WIDTH-1:0] TEN      = DATA_WIDTH'(10);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] snapshot_reg, snapshot_next;
    logic [DATA_WIDTH-1:0] quot_reg, quot_next;
    logic [3:0]            dig_reg [DIGITS];
    logic [3:0]            dig_next [DIGITS];
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  pending_reg, pending_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic [DIGITS*7-1:0]   hex_reg, hex_next;
    logic [DIGITS*7-1:0]   hex_commit;

    logic [3:0] in_mod;
    logic [3:0] quot_mod;
    logic       mismatch;
    logic       last_edge;
    logic       start;

    // Segment pattern gfedcba, active-low; anything outside 0..9 is blank.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign in_mod    = 4'(bus.value_in % TEN);
    assign quot_mod  = 4'(quot_reg % TEN);
    assign mismatch  = (bus.value_in != snapshot_reg);
    assign last_edge = (state_reg == CONV) && (cnt_reg == LAST_CNT);
    // A mismatch on the commit edge does not restart: the commit wins and
    // the following IDLE edge picks up the new value.
    assign start     = (state_reg == IDLE) ? (pending_reg || mismatch)
                                           : (mismatch && !last_edge);

    // Commit image: stored low digits plus the top digit produced this edge.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_enc
            if (gi == DIGITS - 1) begin : g_top
                assign hex_commit[gi*7 +: 7] = encode(quot_mod);
            end else begin : g_low
                assign hex_commit[gi*7 +: 7] = encode(dig_reg[gi]);
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (last_edge) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        snapshot_next = snapshot_reg;
        quot_next     = quot_reg;
        dig_next      = dig_reg;
        cnt_next      = cnt_reg;
        pending_next  = pending_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        hex_next      = hex_reg;
        if (start) begin
            snapshot_next = bus.value_in;
            quot_next     = bus.value_in / TEN;
            dig_next[0]   = in_mod;
            cnt_next      = CNT_W'(1);
            pending_next  = 1'b0;
            busy_next     = 1'b1;
        end else if (state_reg == CONV) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (cnt_reg == CNT_W'(i)) begin
                    dig_next[i] = quot_mod;
                end
            end
            quot_next = quot_reg / TEN;
            cnt_next  = cnt_reg + CNT_W'(1);
            if (last_edge) begin
                hex_next  = hex_commit;
                done_next = 1'b1;
                busy_next = 1'b0;
            end
        end
    end

    // Datapath register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot_reg <= '0;
            quot_reg     <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                dig_reg[i] <= '0;
            end
            cnt_reg      <= '0;
            pending_reg  <= 1'b1;   // guarantees a first conversion, even of 0
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hex_reg      <= '1;
        end else begin
            snapshot_reg <= snapshot_next;
            quot_reg     <= quot_next;
            dig_reg      <= dig_next;
            cnt_reg      <= cnt_next;
            pending_reg  <= pending_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            hex_reg      <= hex_next;
        end
    end

    assign bus.hex_out = hex_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
endmodule

// File: tb/tb_decimal_hex_display.sv
`timescale 1ns/1ps
module tb_decimal_hex_display;
    localparam int DIGITS = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    decimal_hex_display_if #(.DATA_WIDTH(32), .DIGITS(DIGITS)) bus_if ();

    decimal_hex_display #(.DATA_WIDTH(32), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference segment table, indexed by decimal digit.
    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
    end

    // Behavioural model: what the displays must show, in transaction terms.
    logic [41:0] m_hex;
    logic        m_busy, m_done, m_pending, m_active;
    logic [31:0] m_val;
    int          m_edges;

    function automatic logic [41:0] expect_hex(input logic [31:0] v);
        logic [41:0]     h;
        longint unsigned p;
        p = 1;
        h = '0;
        for (int i = 0; i < DIGITS; i++) begin
            h[i*7 +: 7] = seg_tab[int'((longint'(v) / p) % 10)];
            p = p * 10;
        end
        return h;
    endfunction

    task automatic model_reset();
        m_hex = '1; m_busy = 0; m_done = 0; m_pending = 1;
        m_active = 0; m_val = '0; m_edges = 0;
    endtask

    // Effect of one rising edge: a conversion started with value v commits
    // DIGITS edges later unless the input changes before the commit edge.
    task automatic model_edge();
        logic [31:0] v;
        v = bus_if.value_in;
        if (!rst_n) return;
        m_done = 0;
        if (m_active && m_edges == DIGITS - 1) begin
            m_hex    = expect_hex(m_val);
            m_done   = 1;
            m_busy   = 0;
            m_active = 0;
        end else if (m_pending || v != m_val) begin
            m_val     = v;
            m_pending = 0;
            m_active  = 1;
            m_busy    = 1;
            m_edges   = 1;
        end else if (m_active) begin
            m_edges++;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("hex_out", 64'(bus_if.hex_out), 64'(m_hex));
        chk("busy",    64'(bus_if.busy),    64'(m_busy));
        chk("done",    64'(bus_if.done),    64'(m_done));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            $display("edge t=%0t value_in=%0d hex_out=%h busy=%b done=%b",
                     $time, bus_if.value_in, bus_if.hex_out, bus_if.busy, bus_if.done);
        end
    endtask

    task automatic set_val(input logic [31:0] v);
        bus_if.value_in = v;
    endtask

    localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S3 = 7'b0110000,
                           S4 = 7'b0011001, S6 = 7'b0000010, S8 = 7'b0000000,
                           S9 = 7'b0010000;

    initial begin
        logic [31:0] v;
        int hold, sel;
        rst_n = 1'b0;
        bus_if.value_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hex_blank", 64'(bus_if.hex_out), 64'({42{1'b1}}));
        chk("reset_busy", 64'(bus_if.busy), 64'd0);
        rst_n = 1'b1;

        // First conversion of 0 after release: blank until edge 6.
        tick(5);
        chk("lit_blank_edge5", 64'(bus_if.hex_out), 64'({42{1'b1}}));
        chk("lit_busy_edge5", 64'(bus_if.busy), 64'd1);
        tick(1);
        chk("lit_zero_edge6", 64'(bus_if.hex_out), 64'({6{S0}}));
        chk("lit_done_edge6", 64'(bus_if.done), 64'd1);
        tick(2);

        // 0 -> 38
        set_val(32'd38);
        tick(5);
        chk("lit_38_hold", 64'(bus_if.hex_out), 64'({6{S0}}));
        tick(1);
        chk("lit_38", 64'(bus_if.hex_out), 64'({S0, S0, S0, S0, S3, S8}));
        tick(2);

        // 888 then 2^31 (mod 10^6 = 483648)
        set_val(32'd888);
        tick(7);
        chk("lit_888", 64'(bus_if.hex_out), 64'({S0, S0, S0, S8, S8, S8}));
        set_val(32'h8000_0000);
        tick(6);
        chk("lit_483648", 64'(bus_if.hex_out), 64'({S4, S8, S3, S6, S4, S8}));
        tick(2);

        // Abort mid-conversion: 11 switched to 29 on the 3rd conversion edge
        set_val(32'd11);
        tick(3);
        set_val(32'd29);
        tick(5);
        chk("lit_abort_hold", 64'(bus_if.hex_out), 64'({S4, S8, S3, S6, S4, S8}));
        tick(1);
        chk("lit_29", 64'(bus_if.hex_out), 64'({S0, S0, S0, S0, S2, S9}));
        tick(2);

        // 999999 then 1000000 wraps to 000000
        set_val(32'd999999);
        tick(7);
        chk("lit_999999", 64'(bus_if.hex_out), 64'({6{S9}}));
        set_val(32'd1000000);
        tick(7);
        chk("lit_wrap", 64'(bus_if.hex_out), 64'({6{S0}}));

        // Value change coinciding with the commit edge
        set_val(32'd55);
        tick(5);
        set_val(32'd77);
        tick(1);
        chk("lit_coincide_done", 64'(bus_if.done), 64'd1);
        tick(8);

        // Reset asserted during conversion of 123456
        set_val(32'd123456);
        tick(4);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("lit_reset_blank", 64'(bus_if.hex_out), 64'({42{1'b1}}));
        tick(2);
        set_val(32'd42);
        rst_n = 1'b1;
        tick(8);

        // Randomized traffic, with occasional resets
        repeat (150) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       v = $urandom_range(0, 999);
                1:       v = $urandom;
                2:       v = 32'd999990 + $urandom_range(0, 20);
                3:       v = bus_if.value_in;
                default: v = bus_if.value_in ^ (32'd1 << $urandom_range(0, 31));
            endcase
            set_val(v);
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick(1);
                rst_n = 1'b1;
            end
            hold = int'($urandom_range(1, 8));
            tick(hold);
        end
        tick(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
